// File: rtl/wb_dma_adr_seq_if.sv
// Word-address request channel between the DMA address sequencer and the Wishbone master.
// Latency: none (wires only); backpressure: adr/req are held until ack.
interface wb_dma_adr_seq_if;
    logic        req;
    logic [29:0] adr;
    logic        ack;

    modport master (output req, output adr, input ack);
    modport slave  (input req, input adr, output ack);
endinterface

// File: rtl/wb_dma_adr_seq.sv
// Per-channel DMA address sequencer with a split, two-stage 30-bit address incrementor.
// Latency: req one cycle after start/resume, one word per 2 cycles; backpressure: req/adr hold until ack.
module wb_dma_adr_seq #(
    parameter int INC30_CENTER = 16,
    parameter int TSZ_W        = 12,
    parameter int CHK_W        = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [29:0]          adr_in,
    input  logic [TSZ_W-1:0]     tsz_in,
    input  logic [CHK_W-1:0]     chk_sz,
    input  logic                 inc_en,
    input  logic                 resume,
    input  logic                 abort,
    wb_dma_adr_seq_if.master     bus,
    output logic                 busy,
    output logic [TSZ_W-1:0]     tsz_left,
    output logic                 chunk_done,
    output logic                 done,
    output logic                 aborted
);

    localparam int HI_W = 30 - INC30_CENTER;

    typedef enum logic [1:0] {IDLE, ISSUE, INC, CHK_WAIT} state_t;

    state_t                 state, state_nxt;
    logic [29:0]            adr_r;
    logic [INC30_CENTER:0]  lo_r;
    logic [CHK_W-1:0]       chk_cnt;
    logic [CHK_W-1:0]       chk_sz_r;
    logic                   inc_en_r;

    logic ld, take, step, reload, done_set, chunk_set, abort_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        take      = 1'b0;
        step      = 1'b0;
        reload    = 1'b0;
        done_set  = 1'b0;
        chunk_set = 1'b0;
        abort_set = 1'b0;
        // Abort outranks everything, including an ack on the same edge.
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
            abort_set = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (tsz_in == '0) begin
                            done_set = 1'b1;
                        end else begin
                            ld        = 1'b1;
                            state_nxt = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.ack) begin
                        take      = 1'b1;
                        state_nxt = INC;
                    end
                end
                INC: begin
                    step = 1'b1;
                    if (tsz_left == '0) begin
                        state_nxt = IDLE;
                        done_set  = 1'b1;
                    end else if (chk_sz_r != '0 && chk_cnt == '0) begin
                        state_nxt = CHK_WAIT;
                        chunk_set = 1'b1;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
                CHK_WAIT: begin
                    if (resume) begin
                        reload    = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_r      <= '0;
            lo_r       <= '0;
            tsz_left   <= '0;
            chk_cnt    <= '0;
            chk_sz_r   <= '0;
            inc_en_r   <= 1'b0;
            done       <= 1'b0;
            chunk_done <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done       <= done_set;
            chunk_done <= chunk_set;
            aborted    <= abort_set;
            if (ld) begin
                adr_r    <= adr_in;
                tsz_left <= tsz_in;
                chk_cnt  <= chk_sz;
                chk_sz_r <= chk_sz;
                inc_en_r <= inc_en;
            end
            if (take) begin
                lo_r     <= {1'b0, adr_r[INC30_CENTER-1:0]} + (INC30_CENTER+1)'(1);
                tsz_left <= tsz_left - TSZ_W'(1);
                if (chk_sz_r != '0) chk_cnt <= chk_cnt - CHK_W'(1);
            end
            // Second stage: fold the registered low-part carry into the high part.
            if (step && inc_en_r) begin
                adr_r <= {adr_r[29:INC30_CENTER] + HI_W'(lo_r[INC30_CENTER]),
                          lo_r[INC30_CENTER-1:0]};
            end
            if (reload) chk_cnt <= chk_sz_r;
        end
    end

    assign bus.req = (state == ISSUE);
    assign bus.adr = adr_r;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_wb_dma_adr_seq.sv
// Bench for wb_dma_adr_seq: expected addresses queued at start, popped on each accepted transfer.
// Ack is driven either continuously or after a random 0-4 cycle stall.
module tb_wb_dma_adr_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, inc_en, resume, abort;
    logic [29:0] adr_in;
    logic [11:0] tsz_in;
    logic [8:0]  chk_sz;
    logic        busy, chunk_done, done, aborted;
    logic [11:0] tsz_left;

    wb_dma_adr_seq_if bus();

    wb_dma_adr_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .adr_in     (adr_in),
        .tsz_in     (tsz_in),
        .chk_sz     (chk_sz),
        .inc_en     (inc_en),
        .resume     (resume),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .tsz_left   (tsz_left),
        .chunk_done (chunk_done),
        .done       (done),
        .aborted    (aborted)
    );

    int          total = 0;
    int          bad   = 0;
    logic [29:0] exp_q[$];
    int          done_cnt  = 0;
    int          abort_cnt = 0;
    bit          ack_always = 1'b1;
    int          ack_wait   = -1;
    bit          prev_wait  = 1'b0;
    bit          prev_acc   = 1'b0;
    logic [29:0] prev_adr   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ack driver: continuous, or a random stall of 0-4 cycles per request.
    initial begin
        bus.ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ack_always) begin
                bus.ack = 1'b1;
            end else if (!bus.req) begin
                bus.ack  = 1'b0;
                ack_wait = -1;
            end else begin
                if (ack_wait < 0) ack_wait = int'($urandom_range(0, 4));
                if (ack_wait == 0) begin
                    bus.ack  = 1'b1;
                    ack_wait = -1;
                end else begin
                    bus.ack = 1'b0;
                    ack_wait--;
                end
            end
        end
    end

    // Monitor: scoreboard pops, request hold while stalled, one idle cycle after each accept.
    always @(negedge clk) begin
        if (rst) begin
            prev_wait = 1'b0;
            prev_acc  = 1'b0;
        end else begin
            if (done)    done_cnt++;
            if (aborted) abort_cnt++;
            if (prev_acc) check("inc_gap_req", 32'(bus.req), 0);
            if (prev_wait) begin
                check("hold_req", 32'(bus.req), 1);
                check("hold_adr", 32'(bus.adr), 32'(prev_adr));
            end
            prev_acc  = bus.req && bus.ack && !abort;
            prev_wait = bus.req && !bus.ack && !abort;
            prev_adr  = bus.adr;
            if (prev_acc) begin
                if (exp_q.size() == 0) check("sb_extra", 1, 0);
                else                   check("sb_adr", 32'(bus.adr), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic start_xfer(input logic [29:0] a, input int n, input int c, input bit inc);
        logic [29:0] m;
        m = a;
        @(posedge clk); #1;
        adr_in = a;
        tsz_in = 12'(n);
        chk_sz = 9'(c);
        inc_en = inc;
        start  = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(m);
            if (inc) m = m + 30'd1;
        end
        @(posedge clk); #1;
        start  = 1'b0;
        adr_in = 30'($urandom);
        tsz_in = 12'($urandom);
        chk_sz = 9'($urandom);
        inc_en = ~inc;
    endtask

    task automatic wait_done(input int exp_chunks);
        int cyc;
        int nchk;
        bit seen;
        cyc  = 0;
        nchk = 0;
        seen = 1'b0;
        while (!seen && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (chunk_done) begin
                nchk++;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("chk_wait_req", 32'(bus.req), 0);
                end
                @(posedge clk); #1 resume = 1'b1;
                @(posedge clk); #1 resume = 1'b0;
                check("resume_req", 32'(bus.req), 1);
            end else if (done) begin
                seen = 1'b1;
                check("done_busy", 32'(busy), 0);
                check("done_req", 32'(bus.req), 0);
                check("done_tsz_left", 32'(tsz_left), 0);
                check("chunk_count", nchk, exp_chunks);
                check("sb_empty", exp_q.size(), 0);
                @(negedge clk);
                check("done_pulse", 32'(done), 0);
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench stopped by watchdog");
    end

    initial begin
        int a0, d0, cyc;
        rst = 1'b1; start = 1'b0; adr_in = '0; tsz_in = '0; chk_sz = '0;
        inc_en = 1'b0; resume = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.req), 0);
        check("rst_adr", 32'(bus.adr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tsz_left", 32'(tsz_left), 0);
        check("rst_chunk_done", 32'(chunk_done), 0);
        check("rst_done", 32'(done), 0);
        check("rst_aborted", 32'(aborted), 0);
        @(negedge clk) rst = 1'b0;

        // Linear run
        start_xfer(30'h100, 4, 0, 1'b1);
        check("start_req", 32'(bus.req), 1);
        check("start_adr", 32'(bus.adr), 32'h100);
        wait_done(0);

        // Carry across the split and across the top of the address space
        start_xfer(30'h0000_FFFF, 2, 0, 1'b1);
        wait_done(0);
        start_xfer(30'h3FFF_FFFF, 2, 0, 1'b1);
        wait_done(0);

        // Chunking
        start_xfer(30'h200, 5, 2, 1'b1);
        wait_done(2);

        // Fixed address with random ack stalls, then chunking under stalls
        ack_always = 1'b0;
        start_xfer(30'h1234, 3, 0, 1'b0);
        wait_done(0);
        start_xfer(30'h2000, 8, 3, 1'b1);
        wait_done(2);
        ack_always = 1'b1;

        // Abort coinciding with ack at tsz_left = 3
        start_xfer(30'h400, 5, 0, 1'b1);
        a0 = abort_cnt;
        d0 = done_cnt;
        cyc = 0;
        while (!(bus.req && tsz_left == 12'd3) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_reach", 32'(bus.req && tsz_left == 12'd3), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_pulse", 32'(aborted), 1);
        check("abort_req", 32'(bus.req), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_tsz_left", 32'(tsz_left), 3);
        check("abort_adr", 32'(bus.adr), 32'h402);
        repeat (3) @(negedge clk);
        check("abort_count", abort_cnt - a0, 1);
        check("abort_no_done", done_cnt - d0, 0);
        exp_q.delete();

        start_xfer(30'h500, 2, 0, 1'b1);
        check("restart_req", 32'(bus.req), 1);
        check("restart_adr", 32'(bus.adr), 32'h500);
        wait_done(0);

        // Empty transfer
        d0 = done_cnt;
        start_xfer(30'h600, 0, 0, 1'b1);
        check("empty_done", 32'(done), 1);
        check("empty_req", 32'(bus.req), 0);
        check("empty_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("empty_done_end", 32'(done), 0);
        check("empty_req_end", 32'(bus.req), 0);
        @(negedge clk);
        check("empty_done_count", done_cnt - d0, 1);

        // Start while busy is ignored
        start_xfer(30'h700, 3, 0, 1'b1);
        check("busy_start_req", 32'(bus.req), 1);
        adr_in = 30'h55;
        tsz_in = 12'd7;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_tsz", 32'(tsz_left), 2);
        wait_done(0);

        // Reset mid-ISSUE
        start_xfer(30'h800, 4, 0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(bus.req), 0);
        check("mid_rst_adr", 32'(bus.adr), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_tsz_left", 32'(tsz_left), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_chunk_done", 32'(chunk_done), 0);
        check("mid_rst_aborted", 32'(aborted), 0);
        exp_q.delete();
        a0 = abort_cnt;
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_no_done", done_cnt - d0, 0);
        check("post_rst_no_abort", abort_cnt - a0, 0);
        check("post_rst_busy", 32'(busy), 0);

        start_xfer(30'h900, 2, 0, 1'b1);
        wait_done(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
